// File: rtl/ex_cp_issue_buffer_pkg.sv
// Shared EX->complete packet types and ROB age helper (sys_defs slice).
// Defaults for `N, `XLEN and `NUM_ROBS_BITS apply only when the build does not provide them.
`ifndef N
  `define N 2
`endif
`ifndef XLEN
  `define XLEN 32
`endif
`ifndef NUM_ROBS_BITS
  `define NUM_ROBS_BITS 4
`endif

package ex_cp_issue_buffer_pkg;

  typedef struct packed {
    logic                      valid;
    logic [`NUM_ROBS_BITS-1:0] rob_id;
    logic [`XLEN-1:0]          result;
  } EX_CP_PACKET;

  typedef struct packed {
    EX_CP_PACKET pkt;
    logic        live;
  } EX_CP_BUF_ENTRY;

  // Distance from the ROB head; ROB size is a power of two so the subtraction wraps for free.
  function automatic logic [`NUM_ROBS_BITS-1:0] rob_age(
    input logic [`NUM_ROBS_BITS-1:0] id,
    input logic [`NUM_ROBS_BITS-1:0] head
  );
    return id - head;
  endfunction

endpackage

// File: rtl/ex_cp_issue_buffer_rob_age_cmp.sv
// rob_age_cmp: flags an ROB id as younger than the squashing branch, relative to the ROB head.
`ifndef NUM_ROBS_BITS
  `define NUM_ROBS_BITS 4
`endif

module rob_age_cmp
  import ex_cp_issue_buffer_pkg::*;
(
  input  logic [`NUM_ROBS_BITS-1:0] id,
  input  logic [`NUM_ROBS_BITS-1:0] squash_id,
  input  logic [`NUM_ROBS_BITS-1:0] head,
  output logic                      younger
);

  assign younger = rob_age(id, head) > rob_age(squash_id, head);

endmodule

// File: rtl/ex_cp_issue_buffer.sv
// ex_cp_issue_buffer: FIFO between FU results and the complete stage, with squash filtering.
// Optional perf counters are enabled with the EX_CP_PERF_COUNTERS_EN macro.
`ifndef N
  `define N 2
`endif
`ifndef NUM_ROBS_BITS
  `define NUM_ROBS_BITS 4
`endif

module ex_cp_issue_buffer
  import ex_cp_issue_buffer_pkg::*;
#(
  parameter int unsigned NUM_FU    = 4,
  parameter int unsigned BUF_DEPTH = 8,
  parameter int unsigned N         = `N
) (
  input  logic                             clock,
  input  logic                             reset,
  input  EX_CP_PACKET                      fu_pack [NUM_FU],
  output logic [NUM_FU-1:0]                fu_ready,
  input  logic                             need_to_squash,
  input  logic [`NUM_ROBS_BITS-1:0]        squash_younger_than,
  input  logic [`NUM_ROBS_BITS-1:0]        rob_head_pointer,
  output EX_CP_PACKET                      ex_pack [N],
  output logic [$clog2(BUF_DEPTH+1)-1:0]   buf_count
`ifdef EX_CP_PERF_COUNTERS_EN
  ,
  output logic [31:0]                      perf_stall_cycles,
  output logic [31:0]                      perf_squashed,
  output logic [31:0]                      perf_emitted
`endif
);

  localparam int unsigned PTR_W  = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int unsigned SLOT_W = (N > 1) ? $clog2(N) : 1;

  EX_CP_BUF_ENTRY      buf_q [BUF_DEPTH];
  EX_CP_BUF_ENTRY      buf_d [BUF_DEPTH];
  EX_CP_PACKET         ex_d  [N];
  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [BUF_DEPTH-1:0] entry_young, entry_live;
  logic [NUM_FU-1:0]   fu_young;
  logic                accept_ok;
  int unsigned         win, slot, acc, idx;

  assign accept_ok = count_q <= CNT_W'(BUF_DEPTH - NUM_FU);
  assign fu_ready  = accept_ok ? '1 : '0;
  assign buf_count = count_q;

  for (genvar g = 0; g < BUF_DEPTH; g++) begin : g_entry_cmp
    rob_age_cmp u_cmp (
      .id        (buf_q[g].pkt.rob_id),
      .squash_id (squash_younger_than),
      .head      (rob_head_pointer),
      .younger   (entry_young[g])
    );
    assign entry_live[g] = buf_q[g].live && !(need_to_squash && entry_young[g]);
  end

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu_cmp
    rob_age_cmp u_cmp (
      .id        (fu_pack[g].rob_id),
      .squash_id (squash_younger_than),
      .head      (rob_head_pointer),
      .younger   (fu_young[g])
    );
  end

  // Pops and pushes never alias: accepting requires NUM_FU free slots beyond the live window.
  always_comb begin
    buf_d = buf_q;
    for (int unsigned i = 0; i < BUF_DEPTH; i++) buf_d[i].live = entry_live[i];
    for (int unsigned s = 0; s < N; s++) ex_d[s] = '0;
    win  = (32'(count_q) < N) ? 32'(count_q) : N;
    slot = 0;
    acc  = 0;
    idx  = 0;
    for (int unsigned j = 0; j < N; j++) begin
      if (j < win) begin
        idx = (32'(head_q) + j) % BUF_DEPTH;
        if (entry_live[PTR_W'(idx)]) begin
          ex_d[SLOT_W'(slot)]       = buf_q[PTR_W'(idx)].pkt;
          ex_d[SLOT_W'(slot)].valid = 1'b1;
          slot = slot + 1;
        end
        buf_d[PTR_W'(idx)].live = 1'b0;
      end
    end
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      if (fu_pack[f].valid && accept_ok) begin
        idx = (32'(tail_q) + acc) % BUF_DEPTH;
        buf_d[PTR_W'(idx)].pkt  = fu_pack[f];
        buf_d[PTR_W'(idx)].live = !(need_to_squash && fu_young[f]);
        acc = acc + 1;
      end
    end
    head_d  = PTR_W'((32'(head_q) + win) % BUF_DEPTH);
    tail_d  = PTR_W'((32'(tail_q) + acc) % BUF_DEPTH);
    count_d = CNT_W'(32'(count_q) + acc - win);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
      for (int unsigned s = 0; s < N; s++) ex_pack[s] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      buf_q   <= buf_d;
      ex_pack <= ex_d;
    end
  end

`ifdef EX_CP_PERF_COUNTERS_EN
  int unsigned sq_inc;
  logic        any_fu_valid;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input int unsigned b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? '1 : s[31:0];
  endfunction

  always_comb begin
    sq_inc       = 0;
    any_fu_valid = 1'b0;
    for (int unsigned i = 0; i < BUF_DEPTH; i++)
      if (buf_q[i].live && need_to_squash && entry_young[i]) sq_inc = sq_inc + 1;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      any_fu_valid = any_fu_valid | fu_pack[f].valid;
      if (fu_pack[f].valid && accept_ok && need_to_squash && fu_young[f]) sq_inc = sq_inc + 1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_stall_cycles <= '0;
      perf_squashed     <= '0;
      perf_emitted      <= '0;
    end else begin
      perf_stall_cycles <= sat_add(perf_stall_cycles, (!accept_ok && any_fu_valid) ? 1 : 0);
      perf_squashed     <= sat_add(perf_squashed, sq_inc);
      perf_emitted      <= sat_add(perf_emitted, slot);
    end
  end
`endif

endmodule

// File: doc/ex_cp_issue_buffer.md
Name: ex_cp_issue_buffer

Overview:
- Transmitter side of the EX→complete interface: collects finished results from NUM_FU functional units, buffers them in FIFO order, and drives up to `N EX_CP_PACKETs per cycle on ex_pack into the complete stage.
- Drops entries younger than a mispredicted branch, using the same squash inputs as the complete stage.
- Applies backpressure to the FUs when the buffer nears full.

Parameters:
- NUM_FU, 4, number of functional-unit result ports.
- BUF_DEPTH, 8, circular buffer entries; must be ≥ NUM_FU + `N.
- N, `N, output slots per cycle; default is the `N macro (2 for bench).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low; reset==0 at posedge clears state.
- fu_pack  in  [NUM_FU] EX_CP_PACKET  FU results; packet's .valid marks a request.
- fu_ready  out  NUM_FU  per-FU accept; identical value on all bits.
- need_to_squash  in  1  squash request this cycle.
- squash_younger_than  in  `NUM_ROBS_BITS  mispredicting ROB id.
- rob_head_pointer  in  `NUM_ROBS_BITS  ROB head for age compare.
- ex_pack  out  [N] EX_CP_PACKET  registered packets to complete stage.
- buf_count  out  $clog2(BUF_DEPTH+1)  registered occupancy.

Behaviour:
- Reset (reset==0 at posedge):
  - head, tail and count are 0; all entry valid bits are 0.
  - Every ex_pack[i] is all-zero, so .valid=0.
  - buf_count=0; fu_ready=all 1s after reset (combinational from count).
- Accept:
  - fu_pack[i] is accepted when fu_pack[i].valid && fu_ready[i].
  - fu_ready = (buf_count ≤ BUF_DEPTH−NUM_FU) ? all 1s : all 0s.
  - Computed from the registered count only; no combinational path from fu_pack to fu_ready.
- Enqueue: accepted packets are written at tail in ascending FU index; tail advances by the accepted count, modulo BUF_DEPTH.
- Dequeue (each cycle):
  - Scan window is the first min(N, count) entries from head, after the squash filter.
  - Valid entries fill ex_pack[0..] in FIFO order; unused slots are all-zero.
  - Every scanned entry, valid or squashed, is popped; head advances by the window size.
- Latency:
  - A packet accepted at edge k in an empty buffer appears on ex_pack after edge k+1.
  - No same-cycle bypass.
- Count update: count_next = count + accepted − popped; it can never exceed BUF_DEPTH by construction.
- Squash:
  - age(x) = (x − rob_head_pointer) mod 2^`NUM_ROBS_BITS; the ROB size is a power of 2.
  - When need_to_squash=1, any buffered entry or same-cycle incoming packet with age(rob_id) > age(squash_younger_than) is invalidated.
  - The squashing branch itself (equal age) is kept.
  - Invalidated incoming packets are still accepted (they occupy a slot) but marked invalid; they are never emitted.
  - Squash filtering applies to the dequeue scan in the same cycle.
  - The ex_pack value already registered in the squash cycle is not recalled; the complete stage filters it.
- Wrap-around: head and tail wrap modulo BUF_DEPTH; the age compare wraps modulo ROB size.
- Full: with fu_ready low, fu_pack is ignored; the buffer drains N entries per cycle.
- Reset mid-operation: all buffered packets are discarded and nothing is emitted after reset.

Optional Feature:
- Macro EX_CP_PERF_COUNTERS_EN.
- When defined, adds three outputs, all zeroed on reset and saturating:
  - perf_stall_cycles (32 b): cycles with fu_ready low and some fu_pack valid.
  - perf_squashed (32 b): entries invalidated by squash.
  - perf_emitted (32 b): valid packets driven on ex_pack.
- When undefined, these ports and the logic behind them do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package (existing sys_defs):
  - EX_CP_PACKET, `N, `XLEN, `NUM_ROBS_BITS.
  - New: EX_CP_BUF_ENTRY = {EX_CP_PACKET pkt; logic live}.
  - New: function rob_age(id, head).
- One sub-module: rob_age_cmp (pure compare, returns younger flag). It is instantiated per buffer entry and per FU input, and is reused by the complete stage.

Test Plan (N=2, NUM_FU=4, BUF_DEPTH=8, `NUM_ROBS_BITS=4):
- Reset: hold reset=0 for 2 cycles → all ex_pack .valid=0, buf_count=0, fu_ready=4'hF.
- Single packet: FU0 valid, rob_id=3, result=10, at edge k → after edge k+1: ex_pack[0] valid, rob_id=3, result=10; ex_pack[1].valid=0; buf_count returns to 0.
- Ordering: FU0..3 valid with rob_id 0..3 for one cycle → ex_pack {0,1}, then {2,3} on consecutive cycles.
- Backpressure: all 4 FUs valid every cycle → buf_count 4, then 6; fu_ready drops to 0 while count>4. Twelve packets are emitted in FIFO order with none lost or duplicated.
- Squash:
  - Setup: buffer holds rob 1,2,5,6; head=1; squash_younger_than=2; need_to_squash=1.
  - Response: only 1 and 2 are emitted; buf_count reaches 0 after 2 cycles.
- Wrap squash: head=14, squash_younger_than=15, entries rob 15,0,14 → 0 dropped; 15 and 14 emitted in arrival order.
